// File: rtl/adder6_pkg.sv
// Shared widths and scheduler state encoding for the adder6 shared-unit scheduler.
package adder6_pkg;
   localparam int unsigned OPW  = 6;
   localparam int unsigned SUMW = 7;
   localparam int unsigned CNTW = 16;

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } sched_state_t;
endpackage

// File: rtl/adder6.sv
// Shared combinational 6+6 -> 7-bit adder.
module adder6
   import adder6_pkg::*;
(
   input  logic [OPW-1:0]  a_i,
   input  logic [OPW-1:0]  b_i,
   output logic [SUMW-1:0] sum_c
);
   assign sum_c = SUMW'(a_i) + SUMW'(b_i);
endmodule

// File: rtl/adder6_sched_rr_pick.sv
// Round-robin picker: first valid index at or above ptr, wrapping modulo N.
module rr_pick #(
   parameter int unsigned N  = 4,
   parameter int unsigned IW = 2
) (
   input  logic [N-1:0]  valid_i,
   input  logic [IW-1:0] ptr_i,
   output logic [N-1:0]  grant_c,
   output logic [IW-1:0] idx_c,
   output logic          any_c
);
   int unsigned j;

   always_comb begin
      grant_c = '0;
      idx_c   = '0;
      any_c   = 1'b0;
      j       = 0;
      for (int unsigned k = 0; k < N; k++) begin
         j = (32'(ptr_i) + k) % N;
         if (!any_c && valid_i[IW'(j)]) begin
            any_c              = 1'b1;
            idx_c              = IW'(j);
            grant_c[IW'(j)]    = 1'b1;
         end
      end
   end
endmodule

// File: rtl/adder6_sched.sv
// Round-robin scheduler sharing one adder6 among N_REQ requesters; one registered
// response slot with backpressure, accept-and-regrant in the same cycle.
module adder6_sched
   import adder6_pkg::*;
#(
   parameter int unsigned N_REQ = 4,
   parameter int unsigned ID_W  = 2
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [N_REQ-1:0]       req_valid,
   input  logic [OPW*N_REQ-1:0]   req_a,
   input  logic [OPW*N_REQ-1:0]   req_b,
   output logic [N_REQ-1:0]       req_ready,
   output logic                   rsp_valid,
   input  logic                   rsp_ready,
   output logic [SUMW-1:0]        rsp_sum,
   output logic [ID_W-1:0]        rsp_id,
   output logic [CNTW-1:0]        ops_done
);
   sched_state_t      state_q, state_d;
   logic [ID_W-1:0]   ptr_q, ptr_d;
   logic [SUMW-1:0]   sum_q, sum_d;
   logic [ID_W-1:0]   id_q, id_d;
   logic [CNTW-1:0]   ops_q, ops_d;

   logic [N_REQ-1:0]  pick_grant_c;
   logic [ID_W-1:0]   pick_idx_c;
   logic              pick_any_c;
   logic [OPW-1:0]    a_g_c, b_g_c;
   logic [SUMW-1:0]   sum_c;
   logic              slot_free_c, grant_fire_c;

   rr_pick #(.N(N_REQ), .IW(ID_W)) u_pick (
      .valid_i (req_valid),
      .ptr_i   (ptr_q),
      .grant_c (pick_grant_c),
      .idx_c   (pick_idx_c),
      .any_c   (pick_any_c)
   );

   // Operand mux driven only by the grant index, so operands never reach an output combinationally.
   assign a_g_c = req_a[32'(pick_idx_c)*OPW +: OPW];
   assign b_g_c = req_b[32'(pick_idx_c)*OPW +: OPW];

   adder6 u_add (
      .a_i   (a_g_c),
      .b_i   (b_g_c),
      .sum_c (sum_c)
   );

   assign slot_free_c  = (state_q == EMPTY) || rsp_ready;
   assign grant_fire_c = slot_free_c && pick_any_c;
   assign req_ready    = (grant_fire_c && rst_n) ? pick_grant_c : '0;

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      sum_d   = sum_q;
      id_d    = id_q;
      ops_d   = ops_q;
      if (state_q == FULL && rsp_ready) begin
         ops_d   = ops_q + CNTW'(1);
         state_d = EMPTY;
      end
      if (grant_fire_c) begin
         state_d = FULL;
         sum_d   = sum_c;
         id_d    = pick_idx_c;
         ptr_d   = (pick_idx_c == ID_W'(N_REQ - 1)) ? '0 : ID_W'(pick_idx_c + 1'b1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= EMPTY;
         ptr_q   <= '0;
         sum_q   <= '0;
         id_q    <= '0;
         ops_q   <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         sum_q   <= sum_d;
         id_q    <= id_d;
         ops_q   <= ops_d;
      end
   end

   assign rsp_valid = (state_q == FULL);
   assign rsp_sum   = sum_q;
   assign rsp_id    = id_q;
   assign ops_done  = ops_q;
endmodule

// File: doc/adder6_sched.md
# adder6_sched

Round-robin scheduler that shares a single combinational `adder6` among `N_REQ` requesters. Each requester presents a 6-bit operand pair under a valid/ready handshake. The block grants one requester per cycle, registers the 7-bit sum, and returns it with the requester's index on a single response channel with backpressure. It sits between the client logic and the shared adder datapath.

## Interface
- `N_REQ`, default 4: number of requesters, 2..8.
- `ID_W`, default 2: response ID width, equal to $clog2(N_REQ).
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst_n`  in  1: reset, asynchronous and active-low.
- `req_valid`  in  N_REQ: request pending, one bit per requester.
- `req_a`  in  6*N_REQ: operand a; requester i uses bits [6i+5:6i].
- `req_b`  in  6*N_REQ: operand b; same packing as `req_a`.
- `req_ready`  out  N_REQ: grant, one-hot or zero, combinational.
- `rsp_valid`  out  1: response register holds a result.
- `rsp_ready`  in  1: consumer accepts the response.
- `rsp_sum`  out  7: registered a+b, zero-extended, no overflow loss.
- `rsp_id`  out  ID_W: index of the requester that produced `rsp_sum`.
- `ops_done`  out  16: count of accepted responses; wraps at 0xFFFF -> 0.

## Operation
- States:
  - EMPTY: `rsp_valid`=0.
  - FULL: `rsp_valid`=1.
- Slot free condition: the slot is free in a cycle when the state is EMPTY, or when it is FULL and `rsp_ready`=1.
- Grant rule: when the slot is free and any `req_valid` bit is set, grant the first valid index found searching from `ptr` upward, modulo N_REQ.
  - Assert only that requester's `req_ready` bit in the same cycle.
  - At the clock edge, load `rsp_sum`=adder6(a_g,b_g) and `rsp_id`=g, and go to FULL.
  - Set `ptr` to g+1; g=N_REQ-1 wraps `ptr` to 0.
- FULL with `rsp_ready`=0: stall.
  - All `req_ready` bits are 0.
  - `rsp_sum` and `rsp_id` hold their values.
  - `ptr` holds its value.
- FULL with `rsp_ready`=1 and no `req_valid`: go to EMPTY.
- FULL with `rsp_ready`=1 and a request pending: accept the old response and grant the new one in the same cycle. The state stays FULL, so throughput is one operation per cycle.
- `ops_done` increments on every cycle where `rsp_valid` and `rsp_ready` are both 1.
- Requester obligations:
  - Hold `req_valid` and its operands stable until its `req_ready` is sampled high.
  - Deasserting `req_valid` before the grant withdraws the request; the block grants nothing for it.
- `rsp_ready` while EMPTY is ignored.
- `req_valid` bits for indices ≥ N_REQ do not exist; `ptr` ranges 0..N_REQ-1 only.

## Timing
- Reset values, held while `rst_n`=0:
  - State: EMPTY; `rsp_valid`=0.
  - `rsp_sum`=0, `rsp_id`=0.
  - `ptr`=0, `ops_done`=0.
  - `req_ready`=0.
- Reset asserted mid-operation discards any held response. It is not counted in `ops_done`.
- Latency: a grant in cycle t gives `rsp_valid`=1 with the result from cycle t+1.
- `req_ready` depends combinationally on `req_valid`, `rsp_ready`, state and `ptr`. There is no combinational path from `req_a`/`req_b` to any output.
- Sum width: 6+6 -> 7 bits; the maximum value is 63+63=126.

## Structure
- Shared package `adder6_pkg`:
  - `OPW`=6 and `SUMW`=7.
  - Typedef `sched_state_t` with values {EMPTY, FULL}.
- Instantiate the existing `adder6` once, with its inputs muxed by the grant index.
- Sub-module `rr_pick`: purely combinational. It takes `req_valid` and `ptr` and produces a one-hot grant plus an index and an `any` flag. It is reusable by other shared-unit schedulers.

## Test plan
- Single request, requester 2, a=63 b=63 -> `req_ready`=0b0100 in that cycle. Next cycle: `rsp_valid`=1, `rsp_sum`=126, `rsp_id`=2.
- All four valid, `rsp_ready`=1 throughout, `ptr`=0 -> grants 0,1,2,3 on consecutive cycles. `rsp_id` sequence is 0,1,2,3 with no bubbles. `ops_done`=4 afterwards.
- Backpressure: hold `rsp_ready`=0 for 5 cycles with requests pending -> `req_ready`=0. `rsp_sum` and `rsp_id` stay constant. No grant until `rsp_ready`=1.
- Fairness and wrap: `ptr`=3, requesters 0 and 3 valid -> grant 3, then `ptr`=0, then grant 0.
- Exhaustive: every a,b in 0..63 through requester 1 -> `rsp_sum`=a+b on all 4096 operations. `ops_done`=4096.
- Counter and reset: preload 65535 accepted operations, then one more -> `ops_done`=0. Assert `rst_n` low while FULL -> `rsp_valid` drops immediately, and `ptr` and `ops_done` return to 0.
